// File: rtl/onehot_token_rx.sv
// One-hot token pipe receiver: counts arriving pulses, hands them out through valid/pop, returns one credit per pop.
// Tokens are poppable the cycle after arrival. A pop returns a credit exactly CREDIT_LAT cycles later. Arrivals while full are dropped and flagged.
module onehot_token_rx #(
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 3,
  parameter int CREDIT_LAT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_in,
  input  logic             pop,
  input  logic             clr_err,
  output logic             tok_valid,
  output logic [CNT_W-1:0] occ,
  output logic             credit_out,
  output logic             overflow,
  output logic             err_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FULL  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0]      occ_q, occ_d;
  logic                  overflow_q, overflow_d;
  logic [CREDIT_LAT-1:0] credit_q, credit_d;
  state_t                state_q, state_d, occ_state;

  logic pop_eff, acc, drop, full;

  assign full    = (occ_q == DEPTH_C);
  assign pop_eff = pop & (occ_q != '0);
  assign acc     = tok_in & (~full | pop_eff);
  assign drop    = tok_in & ~acc;

  always_comb begin
    occ_d = occ_q;
    if (acc && !pop_eff) begin
      occ_d = occ_q + ONE_C;
    end else if (!acc && pop_eff) begin
      occ_d = occ_q - ONE_C;
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end
  end

  // Credits must never merge, so the chain is a plain shift register of pop pulses.
  generate
    if (CREDIT_LAT == 1) begin : g_credit_one
      assign credit_d = pop_eff;
    end else begin : g_credit_chain
      assign credit_d = {credit_q[CREDIT_LAT-2:0], pop_eff};
    end
  endgenerate

  always_comb begin
    occ_state = ST_HOLD;
    if (occ_d == '0) begin
      occ_state = ST_EMPTY;
    end else if (occ_d == DEPTH_C) begin
      occ_state = ST_FULL;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY, ST_HOLD, ST_FULL: begin
        state_d = drop ? ST_ERR : occ_state;
      end
      ST_ERR: begin
        if (!drop && clr_err) begin
          state_d = occ_state;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q      <= '0;
      overflow_q <= 1'b0;
      credit_q   <= '0;
      state_q    <= ST_EMPTY;
    end else begin
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
      credit_q   <= credit_d;
      state_q    <= state_d;
    end
  end

  assign occ        = occ_q;
  assign tok_valid  = (occ_q != '0);
  assign credit_out = credit_q[CREDIT_LAT-1];
  assign overflow   = overflow_q;
  assign err_state  = (state_q == ST_ERR);

endmodule

// File: tb/tb_onehot_token_rx.sv
// Directed bench for onehot_token_rx with DEPTH=4, CNT_W=3, CREDIT_LAT=5.
module tb_onehot_token_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tok_in;
  logic       pop;
  logic       clr_err;
  logic       tok_valid;
  logic [2:0] occ;
  logic       credit_out;
  logic       overflow;
  logic       err_state;

  int errors = 0;
  int checks = 0;

  onehot_token_rx #(
    .DEPTH     (4),
    .CNT_W     (3),
    .CREDIT_LAT(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tok_in    (tok_in),
    .pop       (pop),
    .clr_err   (clr_err),
    .tok_valid (tok_valid),
    .occ       (occ),
    .credit_out(credit_out),
    .overflow  (overflow),
    .err_state (err_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks credit_out for six cycles after the pop cycle; a pulse is required only on the given offset.
  task automatic chk_credit_window(input string tag, input int hit_a, input int hit_b, input int hit_c);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk(tag, {31'd0, credit_out}, {31'd0, (k == hit_a) || (k == hit_b) || (k == hit_c)});
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_occ"},   {29'd0, occ},        32'd0);
    chk({tag, "_vld"},   {31'd0, tok_valid},  32'd0);
    chk({tag, "_cred"},  {31'd0, credit_out}, 32'd0);
    chk({tag, "_ovf"},   {31'd0, overflow},   32'd0);
    chk({tag, "_err"},   {31'd0, err_state},  32'd0);
  endtask

  initial begin
    rst     = 1'b0;
    tok_in  = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b1;

    // Single token: visible the cycle after arrival, credit 5 cycles after the pop.
    tick();
    tok_in = 1'b1;
    tick();
    tok_in = 1'b0;
    chk("a_occ1", {29'd0, occ}, 32'd1);
    chk("a_vld1", {31'd0, tok_valid}, 32'd1);
    tick();
    chk("a_occ_hold", {29'd0, occ}, 32'd1);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("a_occ0", {29'd0, occ}, 32'd0);
    chk("a_vld0", {31'd0, tok_valid}, 32'd0);
    chk("a_cred_early", {31'd0, credit_out}, 32'd0);
    chk_credit_window("a_credit", 4, 0, 0);

    // Fill to DEPTH, then one drop.
    tok_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("b_occ4", {29'd0, occ}, 32'd4);
    chk("b_ovf0", {31'd0, overflow}, 32'd0);
    chk("b_err0", {31'd0, err_state}, 32'd0);
    tick();
    tok_in = 1'b0;
    chk("b_ovf1", {31'd0, overflow}, 32'd1);
    chk("b_err1", {31'd0, err_state}, 32'd1);
    chk("b_occ_kept", {29'd0, occ}, 32'd4);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("b_clr_ovf", {31'd0, overflow}, 32'd0);
    chk("b_clr_err", {31'd0, err_state}, 32'd0);
    chk("b_clr_occ", {29'd0, occ}, 32'd4);

    // Drop coinciding with clr_err: the drop wins.
    tok_in  = 1'b1;
    clr_err = 1'b1;
    tick();
    tok_in = 1'b0;
    chk("b2_ovf", {31'd0, overflow}, 32'd1);
    chk("b2_err", {31'd0, err_state}, 32'd1);
    tick();
    clr_err = 1'b0;
    chk("b2_clr_ovf", {31'd0, overflow}, 32'd0);
    chk("b2_clr_err", {31'd0, err_state}, 32'd0);

    // Arrival and pop together at full: accepted, no overflow.
    tok_in = 1'b1;
    pop    = 1'b1;
    tick();
    tok_in = 1'b0;
    pop    = 1'b0;
    chk("c_occ4", {29'd0, occ}, 32'd4);
    chk("c_ovf0", {31'd0, overflow}, 32'd0);
    chk("c_err0", {31'd0, err_state}, 32'd0);
    chk_credit_window("c_credit", 4, 0, 0);

    // Three back-to-back pops give three back-to-back credits.
    pop = 1'b1;
    tick();
    tick();
    tick();
    pop = 1'b0;
    chk("d_occ1", {29'd0, occ}, 32'd1);
    chk_credit_window("d_credit", 2, 3, 4);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("d_occ0", {29'd0, occ}, 32'd0);
    chk_credit_window("d_credit_last", 4, 0, 0);

    // Pops while empty are ignored and never produce credits.
    pop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("e_no_credit", {31'd0, credit_out}, 32'd0);
    end
    pop = 1'b0;
    chk("e_occ0", {29'd0, occ}, 32'd0);
    tick();
    chk("e_tail_credit", {31'd0, credit_out}, 32'd0);

    // Reset mid-flight from ERR with a credit in the chain.
    tok_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tok_in = 1'b0;
    chk("f_err", {31'd0, err_state}, 32'd1);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("f_occ3", {29'd0, occ}, 32'd3);
    chk("f_err_kept", {31'd0, err_state}, 32'd1);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("f_async");
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("f_no_credit", {31'd0, credit_out}, 32'd0);
    end
    tok_in = 1'b1;
    tick();
    tok_in = 1'b0;
    chk("f_after_occ", {29'd0, occ}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onehot_token_rx.md
Name: onehot_token_rx

Overview:
- Receiving end of the single-bit one-hot token pipe. The sender launches a token, the token ripples through a fixed-latency stage chain, and it arrives as a one-cycle pulse.
- This block catches the arriving pulses, holds them in a bounded token counter, and presents them to a local consumer through a valid/pop handshake.
- For each consumed token it returns a credit pulse to the sender through a fixed-latency one-hot return chain. The sender can then keep more than one token outstanding.

Parameters:
DEPTH, 4, maximum tokens held; legal range 1..7.
CNT_W, 3, width of occupancy counter; must satisfy 2^CNT_W > DEPTH.
CREDIT_LAT, 5, number of register stages in the credit return chain; legal range >= 1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset; all state clears while rst=0
tok_in  input  1  arriving token pulse; each cycle tok_in=1 counts as one token
pop  input  1  consumer takes one token; effective only when tok_valid=1
clr_err  input  1  synchronous clear of the error state
tok_valid  output  1  at least one token held
occ  output  CNT_W  number of tokens held, 0..DEPTH
credit_out  output  1  one-cycle credit pulse back to the sender
overflow  output  1  sticky; a token arrived while full and was dropped
err_state  output  1  1 while the FSM is in ERR

Behaviour:
- Reset (rst=0, asynchronous): occ=0, tok_valid=0, credit chain all 0, credit_out=0, overflow=0, FSM=EMPTY, err_state=0.
- Reset mid-operation discards held tokens and any credits still in the chain. No credit_out pulse comes out for them after reset releases.
- Effective pop: pop_eff = pop & tok_valid. A pop while tok_valid=0 is ignored; no error.
- Effective accept: acc = tok_in & (occ < DEPTH), or tok_in & pop_eff when occ == DEPTH.
  - Simultaneous arrival and pop at full is accepted and occ stays at DEPTH.
- occ next value:
  - acc & !pop_eff: occ+1
  - !acc & pop_eff: occ-1
  - otherwise: occ unchanged
- occ never wraps. It saturates at 0 and DEPTH by construction.
- tok_valid = (occ != 0), registered-state derived. There is no bypass: a token arriving in cycle N is poppable no earlier than cycle N+1.
- Dropped token: tok_in & !acc. Sets overflow=1 and moves the FSM to ERR. occ is unchanged.
- overflow is cleared only by reset, or by clr_err when no drop occurs in the same cycle. If clr_err and a drop coincide, the drop wins.
- Credit return chain:
  - CREDIT_LAT-bit shift register; stage0 <= pop_eff, stage k <= stage k-1.
  - credit_out = last stage.
  - Latency from the pop cycle to the credit_out pulse is exactly CREDIT_LAT cycles.
  - Back-to-back pops give back-to-back credits; pulses are never merged or lost.
- FSM states and transitions:
  - EMPTY (occ=0): acc goes to HOLD.
  - HOLD (0<occ<DEPTH): occ_next==DEPTH goes to FULL; occ_next==0 goes to EMPTY.
  - FULL (occ=DEPTH): pop_eff without acc goes to HOLD, or to EMPTY if DEPTH==1. A drop goes to ERR.
  - ERR: counting, popping and credit return continue normally. On clr_err with no drop in the same cycle, go to EMPTY, HOLD or FULL according to occ_next.
  - err_state = (state==ERR).
- The credit chain runs identically in every state. The sender's credit accounting must stay consistent even after a drop, because a dropped token never produces a credit.

Test Plan:
- Reset then tok_in pulse at cycle 2, pop at cycle 4 -> occ=1 and tok_valid=1 from cycle 3; occ=0 at cycle 5; credit_out=1 exactly at cycle 9 (CREDIT_LAT=5), one cycle wide.
- 4 consecutive tok_in pulses, no pop -> occ=4, state FULL. A 5th tok_in -> overflow=1, err_state=1, occ stays 4. clr_err next cycle -> overflow=0, state FULL.
- occ=4 and tok_in & pop in the same cycle -> no overflow, occ=4. credit_out pulses 5 cycles later.
- pop held high with occ=0 for 10 cycles -> occ=0, no credit_out pulses ever.
- Pop 3 tokens on consecutive cycles 10,11,12 -> credit_out=1 on cycles 15,16,17 and 0 otherwise.
- Pop at cycle 10, rst=0 asserted asynchronously mid-cycle 12, released at cycle 13 -> all outputs 0 immediately on assertion; no credit_out at cycle 15.
